// File: rtl/cache_maint_controller_pkg.sv
// cache_maint_controller_pkg: cache geometry, maintenance op encoding and controller states
package cache_maint_controller_pkg;
  localparam int LINE_SIZE = 32;
  localparam int ICACHE_SIZE = 1024;
  localparam int DCACHE_SIZE = 1024;
  localparam int L2_SIZE = 4096;
  localparam int L2_ASSOC = 4;
  localparam int IC_SETS = ICACHE_SIZE / LINE_SIZE;
  localparam int DC_SETS = DCACHE_SIZE / LINE_SIZE;
  localparam int L2_SETS = L2_SIZE / LINE_SIZE / L2_ASSOC;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
  localparam int SET_W = $clog2(max2(max2(IC_SETS, DC_SETS), L2_SETS));
  localparam int WAY_W = max2(1, $clog2(L2_ASSOC));
  typedef enum logic [1:0] {MAINT_CLEAN = 2'd0, MAINT_INVAL = 2'd1, MAINT_FLUSH = 2'd2} maint_op_e;
  typedef enum logic [2:0] {IDLE, DRAIN, DC_WALK, L2_WALK, IC_WALK, DONE} maint_state_e;
endpackage

// File: rtl/cache_maint_controller_if.sv
// cache_maint_controller_if: CSR-side request/status and cache-side maintenance handshakes
interface cache_maint_controller_if;
  import cache_maint_controller_pkg::*;
  logic maint_start;
  logic [1:0] maint_op;
  logic maint_busy;
  logic maint_done;
  logic req_block;
  logic l1_idle;
  logic ic_mnt_valid;
  logic ic_mnt_ready;
  logic dc_mnt_valid;
  logic dc_mnt_ready;
  logic l2_mnt_valid;
  logic l2_mnt_ready;
  logic [1:0] mnt_op;
  logic [SET_W-1:0] mnt_set;
  logic [WAY_W-1:0] mnt_way;
  modport master (
    input maint_start, maint_op, l1_idle, ic_mnt_ready, dc_mnt_ready, l2_mnt_ready,
    output maint_busy, maint_done, req_block, ic_mnt_valid, dc_mnt_valid, l2_mnt_valid,
    output mnt_op, mnt_set, mnt_way
  );
  modport slave (
    output maint_start, maint_op, l1_idle, ic_mnt_ready, dc_mnt_ready, l2_mnt_ready,
    input maint_busy, maint_done, req_block, ic_mnt_valid, dc_mnt_valid, l2_mnt_valid,
    input mnt_op, mnt_set, mnt_way
  );
endinterface

// File: rtl/cache_maint_controller_walk_counter.sv
// maint_walk_counter: set/way walker, way inner and set outer, limits reloaded per phase
module maint_walk_counter
  import cache_maint_controller_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             adv,
  input  logic [SET_W-1:0] set_max,
  input  logic [WAY_W-1:0] way_max,
  output logic [SET_W-1:0] set,
  output logic [WAY_W-1:0] way,
  output logic             last
);
  logic [SET_W-1:0] smax;
  logic [WAY_W-1:0] wmax;
  assign last = set == smax && way == wmax;
  // load wins over adv so the final accept of a phase rewinds to (0,0) with the next limits
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      set <= '0;
      way <= '0;
      smax <= '0;
      wmax <= '0;
    end else if (load) begin
      set <= '0;
      way <= '0;
      smax <= set_max;
      wmax <= way_max;
    end else if (adv) begin
      way <= way == wmax ? '0 : way + 1'b1;
      set <= way != wmax ? set : set == smax ? '0 : set + 1'b1;
    end
endmodule

// File: rtl/cache_maint_controller.sv
// cache_maint_controller: blocks cores, drains L1s, then walks dcache, L2 and icache maintenance
module cache_maint_controller
  import cache_maint_controller_pkg::*;
(
  input logic clk,
  input logic reset_n,
  cache_maint_controller_if.master bus
);
  maint_state_e state;
  maint_op_e op;
  logic dc_v, l2_v, ic_v, busy, done;
  logic acc, last, load;
  logic [SET_W-1:0] set_max;
  logic [WAY_W-1:0] way_max;
  always_comb begin
    acc = (dc_v & bus.dc_mnt_ready) | (l2_v & bus.l2_mnt_ready) | (ic_v & bus.ic_mnt_ready);
    load = state == DRAIN || (acc && last);
    set_max = state == DC_WALK ? SET_W'(L2_SETS - 1) : state == L2_WALK ? SET_W'(IC_SETS - 1) : SET_W'(DC_SETS - 1);
    way_max = state == DC_WALK ? WAY_W'(L2_ASSOC - 1) : '0;
  end
  maint_walk_counter u_walk (
    .clk(clk), .reset_n(reset_n), .load(load), .adv(acc),
    .set_max(set_max), .way_max(way_max),
    .set(bus.mnt_set), .way(bus.mnt_way), .last(last)
  );
  assign bus.maint_busy = busy;
  assign bus.req_block = busy;
  assign bus.maint_done = done;
  assign bus.dc_mnt_valid = dc_v;
  assign bus.l2_mnt_valid = l2_v;
  assign bus.ic_mnt_valid = ic_v;
  assign bus.mnt_op = op;
  // icache is never dirty, so a clean ends after the L2 walk
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      op <= MAINT_CLEAN;
      {dc_v, l2_v, ic_v, busy, done} <= '0;
    end else
      case (state)
        IDLE: if (bus.maint_start) begin
          op <= bus.maint_op == 2'd3 ? MAINT_FLUSH : maint_op_e'(bus.maint_op);
          busy <= 1'b1;
          state <= DRAIN;
        end
        DRAIN: if (bus.l1_idle) begin
          dc_v <= 1'b1;
          state <= DC_WALK;
        end
        DC_WALK: if (acc && last) begin
          dc_v <= 1'b0;
          l2_v <= 1'b1;
          state <= L2_WALK;
        end
        L2_WALK: if (acc && last) begin
          l2_v <= 1'b0;
          ic_v <= op != MAINT_CLEAN;
          done <= op == MAINT_CLEAN;
          state <= op == MAINT_CLEAN ? DONE : IC_WALK;
        end
        IC_WALK: if (acc && last) begin
          ic_v <= 1'b0;
          done <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_cache_maint_controller.sv
// tb_cache_maint_controller: vector table of whole-cache operations plus backpressure, re-pulse and reset sequences
module tb_cache_maint_controller;
  import cache_maint_controller_pkg::*;
  typedef struct {
    logic [1:0] op;
    logic [1:0] eop;
    int hold;
    int dly;
    int ic;
  } vec_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int tests = 0, fails = 0, cyc = 0, n_done = 0;
  int n_ops[3];
  bit stall[3];
  logic [SET_W-1:0] s_set[3];
  logic [WAY_W-1:0] s_way[3];
  logic [1:0] s_op[3];
  logic [1:0] exp_op;
  logic [2:0] v, r;
  bit mon_en = 1'b0;
  string cn[3] = '{"dc", "l2", "ic"};
  vec_t vecs[6];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  cache_maint_controller_if bus();
  cache_maint_controller dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // expected walk order: dc/ic set = op index, L2 set = index/4 and way = index%4
  always @(negedge clk) if (mon_en) begin
    v = {bus.ic_mnt_valid, bus.l2_mnt_valid, bus.dc_mnt_valid};
    r = {bus.ic_mnt_ready, bus.l2_mnt_ready, bus.dc_mnt_ready};
    chk("onehot_valid", int'($countones(v) <= 1), 1);
    if (bus.maint_done) n_done++;
    for (int c = 0; c < 3; c++) begin
      if (stall[c]) begin
        chk({cn[c], "_hold_valid"}, v[c], 1);
        chk({cn[c], "_hold_set"}, bus.mnt_set, s_set[c]);
        chk({cn[c], "_hold_way"}, bus.mnt_way, s_way[c]);
        chk({cn[c], "_hold_op"}, bus.mnt_op, s_op[c]);
      end
      if (v[c] && r[c]) begin
        chk({cn[c], "_set"}, bus.mnt_set, c == 1 ? n_ops[c] / L2_ASSOC : n_ops[c]);
        chk({cn[c], "_way"}, bus.mnt_way, c == 1 ? n_ops[c] % L2_ASSOC : 0);
        chk({cn[c], "_op"}, bus.mnt_op, exp_op);
        n_ops[c]++;
      end
      stall[c] = v[c] && !r[c];
      s_set[c] = bus.mnt_set;
      s_way[c] = bus.mnt_way;
      s_op[c] = bus.mnt_op;
    end
  end
  task automatic start_op(input logic [1:0] op, input logic [1:0] eop, input bit idle, output int t0);
    n_ops = '{0, 0, 0};
    stall = '{0, 0, 0};
    exp_op = eop;
    @(posedge clk); #1;
    bus.maint_op = op;
    bus.maint_start = 1'b1;
    bus.l1_idle = idle;
    t0 = cyc;
    @(posedge clk); #1;
    bus.maint_start = 1'b0;
    bus.maint_op = ~op;
  endtask
  task automatic run_op(input logic [1:0] op, input logic [1:0] eop, input int hold, input bit rnd,
                        input int exp_dly, input int exp_ic);
    int t0, dly, d0;
    bit seen;
    d0 = n_done;
    dly = -1;
    seen = 1'b0;
    start_op(op, eop, hold == 0, t0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("drain_req_block", bus.req_block, 1);
      chk("drain_no_valid", {bus.ic_mnt_valid, bus.l2_mnt_valid, bus.dc_mnt_valid}, 0);
      @(posedge clk); #1;
    end
    bus.l1_idle = 1'b1;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (bus.maint_done) begin
        seen = 1'b1;
        dly = cyc - t0;
      end else begin
        @(posedge clk); #1;
        if (rnd) bus.l2_mnt_ready = 1'($urandom_range(0, 1));
      end
    end
    bus.l2_mnt_ready = 1'b1;
    chk("done_seen", seen, 1);
    if (exp_dly >= 0) chk("latency", dly, exp_dly);
    @(negedge clk);
    chk("done_one_cycle", bus.maint_done, 0);
    chk("busy_after", bus.maint_busy, 0);
    chk("dc_ops", n_ops[0], DC_SETS);
    chk("l2_ops", n_ops[1], L2_SETS * L2_ASSOC);
    chk("ic_ops", n_ops[2], exp_ic);
    chk("done_count", n_done - d0, 1);
  endtask
  initial begin
    int t0, d0, dly;
    bit seen;
    vecs[0] = '{op: 2'd2, eop: 2'd2, hold: 0, dly: 194, ic: 32};
    vecs[1] = '{op: 2'd0, eop: 2'd0, hold: 0, dly: 162, ic: 0};
    vecs[2] = '{op: 2'd1, eop: 2'd1, hold: 0, dly: 194, ic: 32};
    vecs[3] = '{op: 2'd3, eop: 2'd2, hold: 0, dly: 194, ic: 32};
    vecs[4] = '{op: 2'd2, eop: 2'd2, hold: 10, dly: 204, ic: 32};
    vecs[5] = '{op: 2'd0, eop: 2'd0, hold: 3, dly: 165, ic: 0};
    bus.maint_start = 1'b0;
    bus.maint_op = 2'd0;
    bus.l1_idle = 1'b1;
    bus.dc_mnt_ready = 1'b1;
    bus.l2_mnt_ready = 1'b1;
    bus.ic_mnt_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.maint_busy, 0);
    chk("rst_done", bus.maint_done, 0);
    chk("rst_req_block", bus.req_block, 0);
    chk("rst_valids", {bus.ic_mnt_valid, bus.l2_mnt_valid, bus.dc_mnt_valid}, 0);
    chk("rst_set_way_op", {bus.mnt_set, bus.mnt_way, bus.mnt_op}, 0);
    reset_n = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) run_op(vecs[i].op, vecs[i].eop, vecs[i].hold, 1'b0, vecs[i].dly, vecs[i].ic);
    run_op(2'd2, 2'd2, 0, 1'b1, -1, IC_SETS);
    // re-pulse start during L2 walk and in the DONE cycle
    d0 = n_done;
    seen = 1'b0;
    dly = -1;
    start_op(2'd2, 2'd2, 1'b1, t0);
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = bus.l2_mnt_valid;
    end
    chk("l2_phase_seen", seen, 1);
    @(posedge clk); #1;
    bus.maint_op = 2'd0;
    bus.maint_start = 1'b1;
    @(posedge clk); #1;
    bus.maint_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      seen = bus.maint_done;
      if (seen) dly = cyc - t0;
    end
    bus.maint_start = 1'b1;
    @(posedge clk); #1;
    bus.maint_start = 1'b0;
    chk("repulse_latency", dly, 194);
    repeat (5) @(negedge clk);
    chk("repulse_busy", bus.maint_busy, 0);
    chk("repulse_done_count", n_done - d0, 1);
    chk("repulse_ic_ops", n_ops[2], IC_SETS);
    chk("repulse_op_kept", bus.mnt_op, 2);
    // reset during the dcache walk, then a full replay
    start_op(2'd2, 2'd2, 1'b1, t0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clk); #1;
      seen = n_ops[0] >= 5;
    end
    chk("dc_op5_seen", seen, 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", bus.maint_busy, 0);
    chk("midrst_req_block", bus.req_block, 0);
    chk("midrst_valids", {bus.ic_mnt_valid, bus.l2_mnt_valid, bus.dc_mnt_valid}, 0);
    chk("midrst_set", bus.mnt_set, 0);
    chk("midrst_op", bus.mnt_op, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_op(2'd2, 2'd2, 0, 1'b0, 194, IC_SETS);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
